// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU core and its serial program loader.
//   bl_state_t      : loader FSM states (BL_CHECK only reachable when
//                     BL_CHECKSUM_EN is defined)
//   uart_rx_state_t : UART receiver FSM states
//   UART_DATA_BITS  : data bits per 8N1 frame
//   UART_IDLE_LEVEL : line level while no frame is in progress
package cpu_pkg;

    typedef enum logic [1:0] {
        BL_IDLE  = 2'd0,
        BL_LOAD  = 2'd1,
        BL_DONE  = 2'd2,
        BL_CHECK = 2'd3
    } bl_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } uart_rx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_bootloader_if.sv
// Program-memory write bus between the loader and the CPU program memory.
//   mem_we   : one-cycle write strobe
//   mem_addr : write address (holds last value when mem_we = 0)
//   mem_data : write data    (holds last value when mem_we = 0)
// Modports: master = loader (drives), slave = memory (receives).
interface uart_bootloader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 7
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    modport master (output mem_we, mem_addr, mem_data);
    modport slave  (input  mem_we, mem_addr, mem_data);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-flop input synchroniser.
// Ports:
//   clk_i        : system clock
//   reset_n_i    : synchronous active-low reset
//   rx_i         : asynchronous serial input, idle high
//   byte_o       : last received byte (valid while byte_valid_o = 1)
//   byte_valid_o : one-cycle pulse in the stop-bit sample cycle, stop bit = 1
//   frame_err_o  : one-cycle pulse in the stop-bit sample cycle, stop bit = 0
// Bits are sampled near their middle: the start bit is re-checked
// CLKS_PER_BIT/2 cycles after the falling edge, every later sample follows
// CLKS_PER_BIT cycles after the previous one.
module uart_rx
    import cpu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      rx_i,
    output logic [UART_DATA_BITS-1:0] byte_o,
    output logic                      byte_valid_o,
    output logic                      frame_err_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(UART_DATA_BITS - 1);

    logic                      rx_meta_reg;
    logic                      rx_sync_reg;
    logic                      rx_prev_reg;
    uart_rx_state_t            state_reg;
    logic [CNT_W-1:0]          cnt_reg;
    logic [BIT_W-1:0]          bit_reg;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic                      stop_sample;

    // Outputs are combinational so that the loader can register the write
    // in the very next cycle.
    assign stop_sample  = (state_reg == RX_STOP) && (cnt_reg == BIT_LAST);
    assign byte_valid_o = stop_sample && rx_sync_reg;
    assign frame_err_o  = stop_sample && !rx_sync_reg;
    assign byte_o       = shift_reg;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            rx_meta_reg <= UART_IDLE_LEVEL;
            rx_sync_reg <= UART_IDLE_LEVEL;
            rx_prev_reg <= UART_IDLE_LEVEL;
            state_reg   <= RX_IDLE;
            cnt_reg     <= '0;
            bit_reg     <= '0;
            shift_reg   <= '0;
        end else begin
            rx_meta_reg <= rx_i;
            rx_sync_reg <= rx_meta_reg;
            rx_prev_reg <= rx_sync_reg;
            case (state_reg)
                RX_IDLE: begin
                    cnt_reg <= '0;
                    if (rx_prev_reg && !rx_sync_reg) begin
                        state_reg <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_reg == HALF_LAST) begin
                        cnt_reg   <= '0;
                        bit_reg   <= '0;
                        // A line already back high was a glitch, not a start bit.
                        state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg   <= '0;
                        shift_reg <= {rx_sync_reg, shift_reg[UART_DATA_BITS-1:1]};
                        bit_reg   <= bit_reg + 1'b1;
                        if (bit_reg == DATA_LAST) begin
                            state_reg <= RX_STOP;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_reg == BIT_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= RX_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/uart_bootloader.sv
// Serial program loader for the 4-bit CPU. While bl_programm_i is high,
// UART bytes are written sequentially into program memory and the CPU is
// held; bl_done_o rises once MEMORY_REGISTERS words have been written.
// Optional feature macro: BL_CHECKSUM_EN -- after the data bytes one more
// byte must equal the 8-bit sum of all data bytes, otherwise bl_error_o is
// set and bl_done_o stays low.
// Ports:
//   clk_i, reset_n_i : clock, synchronous active-low reset
//   bl_programm_i    : asynchronous programming-mode request
//   rx_i             : asynchronous UART input
//   mem              : program-memory write bus (master side)
//   cpu_hold_o       : CPU must not fetch while high
//   bl_done_o        : load complete
//   bl_error_o       : sticky framing / checksum error
module uart_bootloader
    import cpu_pkg::*;
#(
    parameter int CLKS_PER_BIT         = 1042,
    parameter int MEMORY_ADDRESS_WIDTH = 4,
    parameter int MEMORY_REGISTERS     = 16,
    parameter int WORD_WIDTH           = 7
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                bl_programm_i,
    input  logic                rx_i,
    uart_bootloader_if.master   mem,
    output logic                cpu_hold_o,
    output logic                bl_done_o,
    output logic                bl_error_o
);
    localparam int AW = MEMORY_ADDRESS_WIDTH;
    localparam logic [AW-1:0] ADDR_LAST = AW'(MEMORY_REGISTERS - 1);

    logic                      prog_meta_reg;
    logic                      prog_reg;
    bl_state_t                 state_reg;
    logic [AW-1:0]             addr_reg;
    logic                      mem_we_reg;
    logic [AW-1:0]             mem_addr_reg;
    logic [WORD_WIDTH-1:0]     mem_data_reg;
    logic                      done_reg;
    logic                      error_reg;
    logic [UART_DATA_BITS-1:0] rx_byte;
    logic                      byte_valid;
    logic                      frame_err;
`ifdef BL_CHECKSUM_EN
    logic [7:0]                sum_reg;
`else
    // Bits above WORD_WIDTH only matter for the checksum.
    logic                      unused_byte;
    assign unused_byte = &{1'b0, rx_byte};
`endif

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .rx_i         (rx_i),
        .byte_o       (rx_byte),
        .byte_valid_o (byte_valid),
        .frame_err_o  (frame_err)
    );

    assign mem.mem_we   = mem_we_reg;
    assign mem.mem_addr = mem_addr_reg;
    assign mem.mem_data = mem_data_reg;
    assign cpu_hold_o   = (state_reg != BL_IDLE);
    assign bl_done_o    = done_reg;
    assign bl_error_o   = error_reg;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            prog_meta_reg <= 1'b0;
            prog_reg      <= 1'b0;
            state_reg     <= BL_IDLE;
            addr_reg      <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_data_reg  <= '0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
`ifdef BL_CHECKSUM_EN
            sum_reg       <= '0;
`endif
        end else begin
            prog_meta_reg <= bl_programm_i;
            prog_reg      <= prog_meta_reg;
            mem_we_reg    <= 1'b0;
            case (state_reg)
                BL_IDLE: begin
                    if (prog_reg) begin
                        state_reg <= BL_LOAD;
                        addr_reg  <= '0;
                        error_reg <= 1'b0;
`ifdef BL_CHECKSUM_EN
                        sum_reg   <= '0;
`endif
                    end
                end
                BL_LOAD: begin
                    // Abort is checked first so a byte arriving in the same
                    // cycle as the prog fall is never written.
                    if (!prog_reg) begin
                        state_reg <= BL_IDLE;
                    end else if (byte_valid) begin
                        mem_we_reg   <= 1'b1;
                        mem_addr_reg <= addr_reg;
                        mem_data_reg <= rx_byte[WORD_WIDTH-1:0];
                        addr_reg     <= addr_reg + 1'b1;
`ifdef BL_CHECKSUM_EN
                        sum_reg      <= sum_reg + rx_byte;
                        if (addr_reg == ADDR_LAST) state_reg <= BL_CHECK;
`else
                        if (addr_reg == ADDR_LAST) state_reg <= BL_DONE;
`endif
                    end else if (frame_err) begin
                        error_reg <= 1'b1;
                    end
                end
`ifdef BL_CHECKSUM_EN
                BL_CHECK: begin
                    if (!prog_reg) begin
                        state_reg <= BL_IDLE;
                    end else if (byte_valid) begin
                        state_reg <= BL_DONE;
                        done_reg  <= (rx_byte == sum_reg);
                        if (rx_byte != sum_reg) error_reg <= 1'b1;
                    end else if (frame_err) begin
                        state_reg <= BL_DONE;
                        error_reg <= 1'b1;
                    end
                end
`endif
                BL_DONE: begin
                    if (!prog_reg) begin
                        state_reg <= BL_IDLE;
                        done_reg  <= 1'b0;
                    end else begin
`ifndef BL_CHECKSUM_EN
                        done_reg  <= 1'b1;
`endif
                    end
                end
                default: state_reg <= BL_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bootloader.sv
module tb_uart_bootloader;
    localparam int CPB  = 8;
    localparam int AW   = 4;
    localparam int NREG = 16;
    localparam int WW   = 7;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic prog = 1'b0;
    logic rx = 1'b1;
    logic hold, done, err;

    uart_bootloader_if #(.ADDR_W(AW), .DATA_W(WW)) mem_bus ();

    uart_bootloader #(
        .CLKS_PER_BIT         (CPB),
        .MEMORY_ADDRESS_WIDTH (AW),
        .MEMORY_REGISTERS     (NREG),
        .WORD_WIDTH           (WW)
    ) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .bl_programm_i (prog),
        .rx_i          (rx),
        .mem           (mem_bus),
        .cpu_hold_o    (hold),
        .bl_done_o     (done),
        .bl_error_o    (err)
    );

    always #5 clk = ~clk;

    logic [AW+WW-1:0] exp_q[$];
    logic [AW+WW-1:0] obs_q[$];
    int n_checks = 0;
    int n_fail = 0;

    // Observed writes, sampled on the inactive edge.
    always @(negedge clk) begin
        if (mem_bus.mem_we === 1'b1) obs_q.push_back({mem_bus.mem_addr, mem_bus.mem_data});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(CPB);
        end
        rx = stop_bit;
        wait_cycles(CPB);
        rx = 1'b1;
        wait_cycles(CPB);
    endtask

    task automatic push_exp(input int addr, input logic [7:0] b);
        logic [7:0] bv;
        bv = b;
        exp_q.push_back({4'(addr), bv[WW-1:0]});
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rx = ~rx;
            wait_cycles(1);
        end
        n_checks++; if ({hold, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b, expected 000", {hold, done, err}); end
        n_checks++; if (mem_bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b, expected 0", mem_bus.mem_we); end
        n_checks++; if (mem_bus.mem_addr !== 4'd0 || mem_bus.mem_data !== 7'd0) begin n_fail++; $display("FAIL reset_bus: got addr=%0d data=0x%02h, expected 0/0", mem_bus.mem_addr, mem_bus.mem_data); end
        rx = 1'b1;
        wait_cycles(3);
        reset_n = 1'b1;
        wait_cycles(4);
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_no_write: got %0d writes, expected 0", obs_q.size()); obs_q.delete(); end
        $display("test_reset done");
    endtask

    task automatic test_full_load();
        logic [AW+WW-1:0] e, o;
        prog = 1'b1;
        wait_cycles(2);
        n_checks++; if (hold !== 1'b0) begin n_fail++; $display("FAIL hold_latency_early: got %b, expected 0", hold); end
        wait_cycles(1);
        n_checks++; if (hold !== 1'b1) begin n_fail++; $display("FAIL hold_latency: got %b, expected 1", hold); end
        for (int i = 0; i < NREG; i++) begin
            push_exp(i, 8'(i));
            send_byte(8'(i), 1'b1);
        end
        wait_cycles(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL full_load_write: got none, expected addr=%0d data=0x%02h", e[WW+:AW], e[WW-1:0]); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL full_load_write: got addr=%0d data=0x%02h, expected addr=%0d data=0x%02h", o[WW+:AW], o[WW-1:0], e[WW+:AW], e[WW-1:0]); end
                else $display("write addr=%0d data=0x%02h ok", o[WW+:AW], o[WW-1:0]);
            end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL full_load_extra: got %0d extra writes, expected 0", obs_q.size()); obs_q.delete(); end
`ifdef BL_CHECKSUM_EN
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_before_checksum: got %b, expected 0", done); end
        send_byte(8'h78, 1'b1);
`endif
        n_checks++; if ({hold, done, err} !== 3'b110) begin n_fail++; $display("FAIL full_load_done: got hold/done/err=%b, expected 110", {hold, done, err}); end
        prog = 1'b0;
        wait_cycles(4);
        n_checks++; if ({hold, done} !== 2'b00) begin n_fail++; $display("FAIL full_load_release: got hold/done=%b, expected 00", {hold, done}); end
        $display("test_full_load done");
    endtask

    task automatic test_frame_err();
        logic [AW+WW-1:0] e, o;
        prog = 1'b1;
        wait_cycles(4);
        for (int i = 0; i < 3; i++) begin
            push_exp(i, 8'(8'h20 + i));
            send_byte(8'(8'h20 + i), 1'b1);
        end
        send_byte(8'h5A, 1'b0);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL frame_err_flag: got %b, expected 1", err); end
        push_exp(3, 8'h11);
        send_byte(8'h11, 1'b1);
        wait_cycles(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL frame_err_write: got none, expected addr=%0d data=0x%02h", e[WW+:AW], e[WW-1:0]); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL frame_err_write: got addr=%0d data=0x%02h, expected addr=%0d data=0x%02h", o[WW+:AW], o[WW-1:0], e[WW+:AW], e[WW-1:0]); end
                else $display("write addr=%0d data=0x%02h ok", o[WW+:AW], o[WW-1:0]);
            end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL frame_err_extra: got %0d extra writes, expected 0", obs_q.size()); obs_q.delete(); end
        prog = 1'b0;
        wait_cycles(4);
        $display("test_frame_err done");
    endtask

    task automatic test_abort();
        logic [AW+WW-1:0] e, o;
        logic [7:0] pat [5] = '{8'hC3, 8'h81, 8'h7F, 8'h05, 8'hFE};
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL error_sticky_idle: got %b, expected 1", err); end
        prog = 1'b1;
        wait_cycles(4);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL error_clear_entry: got %b, expected 0", err); end
        for (int i = 0; i < 5; i++) begin
            push_exp(i, pat[i]);
            send_byte(pat[i], 1'b1);
        end
        prog = 1'b0;
        wait_cycles(4);
        n_checks++; if ({hold, done} !== 2'b00) begin n_fail++; $display("FAIL abort_flags: got hold/done=%b, expected 00", {hold, done}); end
        prog = 1'b1;
        wait_cycles(4);
        push_exp(0, 8'h2A);
        send_byte(8'h2A, 1'b1);
        wait_cycles(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL abort_write: got none, expected addr=%0d data=0x%02h", e[WW+:AW], e[WW-1:0]); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL abort_write: got addr=%0d data=0x%02h, expected addr=%0d data=0x%02h", o[WW+:AW], o[WW-1:0], e[WW+:AW], e[WW-1:0]); end
                else $display("write addr=%0d data=0x%02h ok", o[WW+:AW], o[WW-1:0]);
            end
        end
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL abort_extra: got %0d extra writes, expected 0", obs_q.size()); obs_q.delete(); end
        prog = 1'b0;
        wait_cycles(4);
        $display("test_abort done");
    endtask

    task automatic test_glitch();
        logic [AW+WW-1:0] e, o;
        prog = 1'b1;
        wait_cycles(4);
        rx = 1'b0;
        wait_cycles(2);
        rx = 1'b1;
        wait_cycles(12 * CPB);
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_no_write: got %0d writes, expected 0", obs_q.size()); obs_q.delete(); end
        push_exp(0, 8'h33);
        send_byte(8'h33, 1'b1);
        wait_cycles(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL glitch_write: got none, expected addr=%0d data=0x%02h", e[WW+:AW], e[WW-1:0]); end
            else begin
                o = obs_q.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL glitch_write: got addr=%0d data=0x%02h, expected addr=%0d data=0x%02h", o[WW+:AW], o[WW-1:0], e[WW+:AW], e[WW-1:0]); end
                else $display("write addr=%0d data=0x%02h ok", o[WW+:AW], o[WW-1:0]);
            end
        end
        prog = 1'b0;
        wait_cycles(4);
        $display("test_glitch done");
    endtask

    task automatic test_idle_ignore();
        send_byte(8'h44, 1'b1);
        wait_cycles(4);
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL idle_ignore: got %0d writes, expected 0", obs_q.size()); obs_q.delete(); end
        n_checks++; if (hold !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got %b, expected 0", hold); end
        $display("test_idle_ignore done");
    endtask

`ifdef BL_CHECKSUM_EN
    task automatic test_checksum_bad();
        prog = 1'b1;
        wait_cycles(4);
        for (int i = 0; i < NREG; i++) send_byte(8'(i), 1'b1);
        n_checks++; if (obs_q.size() != NREG) begin n_fail++; $display("FAIL checksum_writes: got %0d writes, expected %0d", obs_q.size(), NREG); end
        obs_q.delete();
        send_byte(8'h77, 1'b1);
        n_checks++; if ({hold, done, err} !== 3'b101) begin n_fail++; $display("FAIL checksum_bad: got hold/done/err=%b, expected 101", {hold, done, err}); end
        prog = 1'b0;
        wait_cycles(4);
        n_checks++; if (hold !== 1'b0) begin n_fail++; $display("FAIL checksum_release: got %b, expected 0", hold); end
        $display("test_checksum_bad done");
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_frame_err();
        test_abort();
        test_glitch();
        test_idle_ignore();
`ifdef BL_CHECKSUM_EN
        test_checksum_bad();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
